// File: rtl/sc_leak_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : sc_leak_monitor_if
//  Description : Bundle of the signals between the two RSA copies and the
//                leak monitor.
//                master : the RSA side (drives start, assumptions, the two
//                         finish levels and decrypted messages; observes
//                         results)
//                slave  : the monitor (consumes the above, drives
//                         busy/done/cycles_*/delta/leak flags/timeout)
//  Revision    : 1.0  initial release
// ============================================================================
interface sc_leak_monitor_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                   KeyGenStart;
    logic                   assume_ok;
    logic                   finish_1;
    logic                   finish_2;
    logic [2*WIDTH-1:0]     m_decrypted_1;
    logic [2*WIDTH-1:0]     m_decrypted_2;

    logic                   busy;
    logic                   done;
    logic [CNT_WIDTH-1:0]   cycles_1;
    logic [CNT_WIDTH-1:0]   cycles_2;
    logic [CNT_WIDTH-1:0]   delta;
    logic                   leak_timing;
    logic                   leak_value;
    logic                   timeout;
    logic                   leak_sticky;

    modport master (
        output KeyGenStart, assume_ok, finish_1, finish_2,
               m_decrypted_1, m_decrypted_2,
        input  busy, done, cycles_1, cycles_2, delta,
               leak_timing, leak_value, timeout, leak_sticky
    );

    modport slave (
        input  KeyGenStart, assume_ok, finish_1, finish_2,
               m_decrypted_1, m_decrypted_2,
        output busy, done, cycles_1, cycles_2, delta,
               leak_timing, leak_value, timeout, leak_sticky
    );
endinterface
`default_nettype wire

// File: rtl/sc_leak_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sc_leak_monitor
//  Description : Lockstep timing/value monitor for two self-composed RSA
//                copies. Counts cycles from a KeyGenStart rising edge to each
//                copy's first finish, latches the decrypted messages, and
//                reports timing / value mismatches once both copies have
//                finished or TIMEOUT RUN cycles have elapsed.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low reset
//                bus   - sc_leak_monitor_if.slave (start, assumptions,
//                        finish levels, messages in; busy, done, cycle
//                        counts, delta, leak flags, timeout out)
//  Revision    : 1.0  initial release
// ============================================================================
module sc_leak_monitor #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 4096
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    sc_leak_monitor_if.slave    bus
);

    localparam logic [CNT_WIDTH-1:0] c_RC_MAX  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] c_RC_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_kgs_q;
    logic [CNT_WIDTH-1:0]   r_rc;
    logic                   r_f1;
    logic                   r_f2;
    logic [2*WIDTH-1:0]     r_m1;
    logic [2*WIDTH-1:0]     r_m2;

    logic                   r_busy;
    logic                   r_done;
    logic [CNT_WIDTH-1:0]   r_cycles_1;
    logic [CNT_WIDTH-1:0]   r_cycles_2;
    logic [CNT_WIDTH-1:0]   r_delta;
    logic                   r_leak_timing;
    logic                   r_leak_value;
    logic                   r_timeout;
    logic                   r_leak_sticky;

    // "Next" view of the latches and captures, so a finish arriving in the
    // same cycle as the report decision is already included in the report.
    logic                   w_start_edge;
    logic                   w_cap_1;
    logic                   w_cap_2;
    logic                   w_f1_nxt;
    logic                   w_f2_nxt;
    logic                   w_both;
    logic [CNT_WIDTH-1:0]   w_c1_nxt;
    logic [CNT_WIDTH-1:0]   w_c2_nxt;
    logic [2*WIDTH-1:0]     w_m1_nxt;
    logic [2*WIDTH-1:0]     w_m2_nxt;
    logic [CNT_WIDTH-1:0]   w_delta;
    logic                   w_leak_timing;
    logic                   w_leak_value;

    assign w_start_edge  = bus.KeyGenStart & ~r_kgs_q;
    assign w_cap_1       = bus.finish_1 & ~r_f1;
    assign w_cap_2       = bus.finish_2 & ~r_f2;
    assign w_f1_nxt      = r_f1 | bus.finish_1;
    assign w_f2_nxt      = r_f2 | bus.finish_2;
    assign w_both        = w_f1_nxt & w_f2_nxt;
    assign w_c1_nxt      = w_cap_1 ? r_rc : r_cycles_1;
    assign w_c2_nxt      = w_cap_2 ? r_rc : r_cycles_2;
    assign w_m1_nxt      = w_cap_1 ? bus.m_decrypted_1 : r_m1;
    assign w_m2_nxt      = w_cap_2 ? bus.m_decrypted_2 : r_m2;
    assign w_delta       = (w_c1_nxt >= w_c2_nxt) ? (w_c1_nxt - w_c2_nxt)
                                                  : (w_c2_nxt - w_c1_nxt);
    assign w_leak_timing = (w_f1_nxt ^ w_f2_nxt) | (w_both & (w_c1_nxt != w_c2_nxt));
    assign w_leak_value  = w_both & (w_m1_nxt != w_m2_nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_kgs_q       <= 1'b0;
            r_rc          <= '0;
            r_f1          <= 1'b0;
            r_f2          <= 1'b0;
            r_m1          <= '0;
            r_m2          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cycles_1    <= '0;
            r_cycles_2    <= '0;
            r_delta       <= '0;
            r_leak_timing <= 1'b0;
            r_leak_value  <= 1'b0;
            r_timeout     <= 1'b0;
            r_leak_sticky <= 1'b0;
        end else begin
            r_kgs_q <= bus.KeyGenStart;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge && bus.assume_ok) begin
                        r_state       <= ST_RUN;
                        r_busy        <= 1'b1;
                        r_rc          <= '0;
                        r_f1          <= 1'b0;
                        r_f2          <= 1'b0;
                        r_cycles_1    <= '0;
                        r_cycles_2    <= '0;
                        r_delta       <= '0;
                        r_leak_timing <= 1'b0;
                        r_leak_value  <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.assume_ok) begin
                        // Invalid run: discard anything captured, no report.
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_cycles_1 <= '0;
                        r_cycles_2 <= '0;
                    end else begin
                        if (w_cap_1) begin
                            r_f1       <= 1'b1;
                            r_cycles_1 <= r_rc;
                            r_m1       <= bus.m_decrypted_1;
                        end
                        if (w_cap_2) begin
                            r_f2       <= 1'b1;
                            r_cycles_2 <= r_rc;
                            r_m2       <= bus.m_decrypted_2;
                        end
                        if (r_rc != c_RC_MAX) begin
                            r_rc <= r_rc + 1'b1;
                        end
                        if (w_both || (r_rc == c_RC_LAST)) begin
                            r_state       <= ST_REPORT;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_timeout     <= ~w_both;
                            r_delta       <= w_delta;
                            r_leak_timing <= w_leak_timing;
                            r_leak_value  <= w_leak_value;
                            r_leak_sticky <= r_leak_sticky | w_leak_timing | w_leak_value;
                        end
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.cycles_1    = r_cycles_1;
    assign bus.cycles_2    = r_cycles_2;
    assign bus.delta       = r_delta;
    assign bus.leak_timing = r_leak_timing;
    assign bus.leak_value  = r_leak_value;
    assign bus.timeout     = r_timeout;
    assign bus.leak_sticky = r_leak_sticky;

endmodule
`default_nettype wire

// File: tb/tb_sc_leak_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_leak_monitor
//  Description : Self-checking bench for sc_leak_monitor: directed vector
//                table, abort and mid-run reset sequences, and randomized
//                runs against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sc_leak_monitor;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 16;
    localparam int TIMEOUT   = 32;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    bit exp_sticky;

    sc_leak_monitor_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    sc_leak_monitor #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k1;
        int          k2;
        logic [15:0] m1;
        logic [15:0] m2;
        int          off;
        int          c1;
        int          c2;
        int          d;
        bit          lt;
        bit          lv;
        bit          to;
        bit          st;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One accepted run. k = -1 means that copy never finishes. The copy's
    // message equals m only in its first finish cycle; before and after,
    // both the message and the finish level carry noise.
    task automatic run_case(input string nm, input int k1, input int k2,
                            input logic [15:0] m1, input logic [15:0] m2,
                            input int e_off, input int e_c1, input int e_c2,
                            input int e_d, input bit e_lt, input bit e_lv,
                            input bit e_to, input bit e_st);
        int  off;
        bit  got;
        logic [CNT_WIDTH-1:0] d_hold;
        bus.KeyGenStart = 1'b0;
        bus.assume_ok   = 1'b1;
        bus.finish_1    = 1'b0;
        bus.finish_2    = 1'b0;
        step();
        bus.KeyGenStart = 1'b1;
        step();
        check({nm, "_busy_run"}, 32'(bus.busy), 32'd1);
        got = 1'b0;
        off = 0;
        for (int j = 1; j <= TIMEOUT + 4 && !got; j++) begin
            int k;
            k = j - 1;
            bus.KeyGenStart   = k[1];
            bus.finish_1      = (k1 >= 0 && k == k1) ? 1'b1 :
                                (k1 >= 0 && k > k1) ? 1'($urandom) : 1'b0;
            bus.finish_2      = (k2 >= 0 && k == k2) ? 1'b1 :
                                (k2 >= 0 && k > k2) ? 1'($urandom) : 1'b0;
            bus.m_decrypted_1 = (k == k1) ? m1 : 16'($urandom);
            bus.m_decrypted_2 = (k == k2) ? m2 : 16'($urandom);
            step();
            if (bus.done === 1'b1) begin
                got = 1'b1;
                off = j + 1;
            end
        end
        check({nm, "_done_seen"}, 32'(got), 32'd1);
        check({nm, "_done_cycle"}, 32'(off), 32'(e_off));
        check({nm, "_cycles_1"}, 32'(bus.cycles_1), 32'(e_c1));
        check({nm, "_cycles_2"}, 32'(bus.cycles_2), 32'(e_c2));
        check({nm, "_delta"}, 32'(bus.delta), 32'(e_d));
        check({nm, "_leak_timing"}, 32'(bus.leak_timing), 32'(e_lt));
        check({nm, "_leak_value"}, 32'(bus.leak_value), 32'(e_lv));
        check({nm, "_timeout"}, 32'(bus.timeout), 32'(e_to));
        check({nm, "_leak_sticky"}, 32'(bus.leak_sticky), 32'(e_st));
        check({nm, "_busy_report"}, 32'(bus.busy), 32'd0);
        d_hold = bus.delta;
        bus.KeyGenStart = 1'b0;
        bus.finish_1    = 1'b0;
        bus.finish_2    = 1'b0;
        step();
        check({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({nm, "_delta_hold"}, 32'(bus.delta), 32'(d_hold));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_sticky = 1'b0;

        //             k1  k2  m1        m2        off c1 c2 d  lt lv to st
        tbl[0] = '{20, 20, 16'h1234, 16'h1234, 22, 20, 20, 0, 0, 0, 0, 0};
        tbl[1] = '{20, 27, 16'h1234, 16'h1234, 29, 20, 27, 7, 1, 0, 0, 1};
        tbl[2] = '{ 5,  5, 16'h00AA, 16'h00AB,  7,  5,  5, 0, 0, 1, 0, 1};
        tbl[3] = '{ 3, -1, 16'h5555, 16'h0000, TIMEOUT+1, 3, 0, 3, 1, 0, 1, 1};
        tbl[4] = '{-1, -1, 16'h0000, 16'h0000, TIMEOUT+1, 0, 0, 0, 0, 0, 1, 1};
        tbl[5] = '{TIMEOUT-1, 0, 16'hBEEF, 16'hBEEF, TIMEOUT+1, TIMEOUT-1, 0, TIMEOUT-1, 1, 0, 0, 1};
        tbl[6] = '{ 0,  0, 16'hCAFE, 16'hCAFE,  2,  0,  0, 0, 0, 0, 0, 1};

        rst_n             = 1'b0;
        bus.KeyGenStart   = 1'b0;
        bus.assume_ok     = 1'b0;
        bus.finish_1      = 1'b0;
        bus.finish_2      = 1'b0;
        bus.m_decrypted_1 = '0;
        bus.m_decrypted_2 = '0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cycles_1", 32'(bus.cycles_1), 32'd0);
        check("rst_delta", 32'(bus.delta), 32'd0);
        check("rst_leak_sticky", 32'(bus.leak_sticky), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_case($sformatf("vec%0d", i), tbl[i].k1, tbl[i].k2, tbl[i].m1, tbl[i].m2,
                     tbl[i].off, tbl[i].c1, tbl[i].c2, tbl[i].d,
                     tbl[i].lt, tbl[i].lv, tbl[i].to, tbl[i].st);
        end

        // Abort: assume_ok drops at k=4, no report follows.
        begin
            bit saw_done;
            bus.KeyGenStart = 1'b0;
            bus.assume_ok   = 1'b1;
            step();
            bus.KeyGenStart = 1'b1;
            step();
            bus.KeyGenStart = 1'b0;
            for (int k = 0; k < 4; k++) step();
            bus.assume_ok = 1'b0;
            step();
            check("abort_busy", 32'(bus.busy), 32'd0);
            check("abort_leak_timing", 32'(bus.leak_timing), 32'd0);
            check("abort_timeout", 32'(bus.timeout), 32'd0);
            check("abort_sticky_kept", 32'(bus.leak_sticky), 32'd1);
            saw_done = 1'b0;
            bus.assume_ok = 1'b1;
            for (int k = 0; k < 6; k++) begin
                step();
                if (bus.done === 1'b1) saw_done = 1'b1;
            end
            check("abort_no_done", 32'(saw_done), 32'd0);
            bus.assume_ok   = 1'b0;
            bus.KeyGenStart = 1'b1;
            step();
            step();
            check("start_without_ok_ignored", 32'(bus.busy), 32'd0);
            bus.KeyGenStart = 1'b0;
            step();
        end

        // Synchronous reset in the middle of a run that has captured copy 1.
        bus.assume_ok   = 1'b1;
        bus.KeyGenStart = 1'b1;
        step();
        bus.KeyGenStart = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.finish_1 = (k >= 3);
            step();
        end
        rst_n = 1'b0;
        step();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_cycles_1", 32'(bus.cycles_1), 32'd0);
        check("midrst_leak_sticky", 32'(bus.leak_sticky), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        rst_n        = 1'b1;
        bus.finish_1 = 1'b0;
        run_case("post_rst", 4, 4, 16'h0F0F, 16'h0F0F, 6, 4, 4, 0, 0, 0, 0, 0);

        // Randomized runs against an arithmetic model of the report rules.
        exp_sticky = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int k1, k2, c1, c2, e_off, e_d;
            bit f1, f2, lt, lv, to;
            logic [15:0] m1, m2;
            k1 = int'($urandom_range(0, TIMEOUT + 8));
            k2 = ($urandom_range(0, 3) == 0) ? k1 : int'($urandom_range(0, TIMEOUT + 8));
            if (k1 >= TIMEOUT) k1 = -1;
            if (k2 >= TIMEOUT) k2 = -1;
            m1 = 16'($urandom);
            m2 = $urandom_range(0, 1) ? m1 : (m1 ^ (16'd1 << $urandom_range(0, 15)));
            f1 = (k1 >= 0);
            f2 = (k2 >= 0);
            c1 = f1 ? k1 : 0;
            c2 = f2 ? k2 : 0;
            to = !(f1 && f2);
            e_off = to ? TIMEOUT + 1 : ((k1 > k2 ? k1 : k2) + 2);
            e_d = (c1 > c2) ? c1 - c2 : c2 - c1;
            lt = (f1 != f2) || (f1 && f2 && c1 != c2);
            lv = f1 && f2 && (m1 != m2);
            exp_sticky = exp_sticky | lt | lv;
            run_case($sformatf("rnd%0d", n), k1, k2, m1, m2, e_off, c1, c2, e_d,
                     lt, lv, to, exp_sticky);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sc_leak_monitor.md
# sc_leak_monitor

Lockstep timing/value monitor for the two-copy RSA self-composition. It sits downstream of the two RSA instances, consumes each copy's `finish` and `m_decrypted`, and counts cycles from the shared `KeyGenStart` to each copy's first `finish`. When both copies have finished, or a timeout expires, it reports whether the finish times or the decrypted values differ, which is a secret-dependent timing or value leak.

## Interface
- `WIDTH`, 8, prime width; message width is 2*WIDTH
- `CNT_WIDTH`, 16, cycle-counter width
- `TIMEOUT`, 4096, maximum RUN cycles before forced report (must be < 2^CNT_WIDTH)

- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `KeyGenStart`  in  1  shared start to both RSA copies
- `assume_ok`  in  1  AND of all four prime assumptions; a run is valid only when high
- `finish_1`, `finish_2`  in  1  per-copy finish level
- `m_decrypted_1`, `m_decrypted_2`  in  2*WIDTH  per-copy decrypted message
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse in REPORT
- `cycles_1`, `cycles_2`  out  CNT_WIDTH  captured finish cycle per copy
- `delta`  out  CNT_WIDTH  |cycles_1 − cycles_2|
- `leak_timing`  out  1  finish-time mismatch
- `leak_value`  out  1  decrypted-value mismatch
- `timeout`  out  1  run ended by TIMEOUT
- `leak_sticky`  out  1  OR of all reported leaks since reset

## Operation
- States: IDLE, RUN, REPORT. All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- Start is a rising edge of `KeyGenStart`. The previous value is held in a register that resets to 0.
- IDLE→RUN requires a start edge with `assume_ok`=1. On entry:
  - running counter `rc`, finish latches `f1`/`f2`, `cycles_*`, `delta` and the three leak flags are all cleared
  - `leak_sticky` is kept
- A start edge with `assume_ok`=0 is ignored and the state stays IDLE.
- In RUN, `rc` = 0 in the first RUN cycle and increments by 1 each cycle. It saturates at TIMEOUT.
- In RUN, if `finish_i`=1 and `f_i`=0:
  - set `f_i`
  - capture `cycles_i` ← `rc`
  - capture the message register `mi` ← `m_decrypted_i`
  - Later `finish_i` activity is ignored.
- RUN→REPORT when both latches are set, counting captures made this cycle. Both copies finishing in the same cycle yields `cycles_1`=`cycles_2`.
- RUN→REPORT with `timeout`=1 when `rc`=TIMEOUT−1 and the latches are not both set after this cycle.
- RUN→IDLE abort if `assume_ok`=0 in any RUN cycle. The abort takes priority over capture in that cycle, and there is no report. Result outputs keep their cleared values.
- `KeyGenStart` edges during RUN or REPORT are ignored.
- REPORT lasts exactly one cycle, with `done`=1. The following outputs become valid in that cycle and hold until the next accepted start or reset:
  - `delta` = absolute difference, computed in CNT_WIDTH bits unsigned
  - `leak_timing` = (f1 XOR f2) OR (f1 AND f2 AND cycles_1≠cycles_2)
  - `leak_value` = f1 AND f2 AND m1≠m2 (never set on a one-sided timeout)
  - `leak_sticky` |= `leak_timing` | `leak_value`
  - On timeout with neither finished, both leak flags are 0 and `timeout`=1.
- REPORT→IDLE unconditionally.

## Timing
- The start edge is sampled in cycle S, and RUN begins at S+1 (`busy`=1, `rc`=0).
- A finish sampled in cycle S+1+k gives `cycles_i`=k.
- The second finish sampled in cycle T gives `done`=1 in cycle T+1. The leak outputs update in that same cycle T+1.
- Timeout: the last RUN cycle is S+TIMEOUT. REPORT is at S+TIMEOUT+1.
- Minimum period between accepted starts is 3 cycles: start, RUN, REPORT.
- Synchronous reset mid-run: on the next edge every output goes to 0 and the state to IDLE, and `leak_sticky` is cleared.

## Test plan
- Both finish at k=20 with equal m=16'h1234 → `done` at S+22, `cycles_1`=`cycles_2`=20, `delta`=0, all leak flags 0.
- finish_1 at k=20, finish_2 at k=27, equal m → `done` at S+29, `delta`=7, `leak_timing`=1, `leak_sticky`=1.
- Both finish at k=5, m1=16'h00AA, m2=16'h00AB → `leak_value`=1, `leak_timing`=0.
- finish_1 at k=3, finish_2 never, TIMEOUT=16 → `done` at S+17, `timeout`=1, `leak_timing`=1, `leak_value`=0, `cycles_2`=0.
- `assume_ok` drops at k=4 → return to IDLE, no `done`, then `busy`=0. A start with `assume_ok`=0 is ignored.
- `rst_n`=0 at k=10 of a run that already has `leak_sticky`=1 → all outputs 0 the next cycle. A new start runs normally, and a second `KeyGenStart` edge during RUN is ignored.
